// File: rtl/mem_ctrler_if.sv
// Line-request handshakes for the data/instruction requesters plus the 8-bit RAM/IO pins of mem_ctrler.
// slave = controller view, master = requester/memory view.
interface mem_ctrler_if #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32
);
    logic                    d_valid;
    logic                    d_rw_flag;
    logic [ADDR_W-1:0]       d_addr;
    logic [8*LINE_BYTES-1:0] d_line_in;
    logic                    d_ready;
    logic [8*LINE_BYTES-1:0] d_line_out;

    logic                    i_valid;
    logic [ADDR_W-1:0]       i_addr;
    logic                    i_ready;
    logic [8*LINE_BYTES-1:0] i_line_out;

    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [ADDR_W-1:0]       mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;

    modport slave (
        input  d_valid, d_rw_flag, d_addr, d_line_in,
        output d_ready, d_line_out,
        input  i_valid, i_addr,
        output i_ready, i_line_out,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output d_valid, d_rw_flag, d_addr, d_line_in,
        input  d_ready, d_line_out,
        output i_valid, i_addr,
        input  i_ready, i_line_out,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrler.sv
// Serialises whole-line d/i requests into byte accesses; read ready in cycle LINE_BYTES+2, write in LINE_BYTES+1.
// rdy=0 freezes everything; a full IO sink stalls IO-region writes byte by byte.
module mem_ctrler #(
    parameter int LINE_BYTES = 16,
    parameter int OFFSET_W   = 4,
    parameter int ADDR_W     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrler_if.slave bus
);
    localparam int                LINE_W = 8 * LINE_BYTES;
    localparam int                CNT_W  = OFFSET_W + 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(LINE_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mem_a;
    logic [7:0]          r_mem_dout;
    logic                r_wr_en;
    logic                r_src_i;
    logic [LINE_W-1:0]   r_line;
    logic [LINE_W-1:0]   r_d_line_out;
    logic [LINE_W-1:0]   r_i_line_out;
    logic                r_d_ready;
    logic                r_i_ready;
    logic                r_d_mask;
    logic                r_i_mask;

    logic                w_d_take;
    logic                w_i_take;
    logic                w_io_stall;
    logic [ADDR_W-1:0]   w_d_base;
    logic [ADDR_W-1:0]   w_i_base;
    logic [ADDR_W-1:0]   w_next_a;
    logic [OFFSET_W-1:0] w_cap_idx;
    logic [OFFSET_W-1:0] w_nxt_idx;
    logic [LINE_W-1:0]   w_line_cap;

    assign w_d_base  = bus.d_addr & ~ADDR_W'(LINE_BYTES - 1);
    assign w_i_base  = bus.i_addr & ~ADDR_W'(LINE_BYTES - 1);
    assign w_next_a  = r_mem_a + ADDR_W'(1);
    assign w_d_take  = bus.d_valid && !r_d_mask;
    assign w_i_take  = bus.i_valid && !r_i_mask && !w_d_take;
    // mem_a never leaves the line, so its bits [17:16] are the base's region bits
    assign w_io_stall = bus.io_buffer_full && (r_mem_a[17:16] == 2'b11);
    assign w_cap_idx = r_cnt[OFFSET_W-1:0] - OFFSET_W'(1);
    assign w_nxt_idx = r_cnt[OFFSET_W-1:0] + OFFSET_W'(1);

    always_comb begin
        w_line_cap = r_line;
        w_line_cap[8*w_cap_idx +: 8] = bus.mem_din;
    end

    assign bus.mem_a      = r_mem_a;
    assign bus.mem_dout   = r_mem_dout;
    assign bus.mem_wr     = r_wr_en && rdy && !w_io_stall;
    assign bus.d_ready    = r_d_ready;
    assign bus.i_ready    = r_i_ready;
    assign bus.d_line_out = r_d_line_out;
    assign bus.i_line_out = r_i_line_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_wr_en      <= 1'b0;
            r_src_i      <= 1'b0;
            r_line       <= '0;
            r_d_line_out <= '0;
            r_i_line_out <= '0;
            r_d_ready    <= 1'b0;
            r_i_ready    <= 1'b0;
            r_d_mask     <= 1'b0;
            r_i_mask     <= 1'b0;
        end else if (rdy) begin
            r_d_ready <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_mask  <= 1'b0;
            r_i_mask  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_d_take || w_i_take) begin
                        r_src_i <= !w_d_take;
                        r_mem_a <= w_d_take ? w_d_base : w_i_base;
                        r_cnt   <= '0;
                        if (w_d_take && bus.d_rw_flag) begin
                            r_line     <= bus.d_line_in;
                            r_mem_dout <= bus.d_line_in[7:0];
                            r_wr_en    <= 1'b1;
                            r_state    <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // byte r_cnt-1 is on mem_din now; address runs one byte ahead of capture
                    if (r_cnt != '0) r_line <= w_line_cap;
                    if (r_cnt == FULL) begin
                        r_state   <= S_DONE;
                        r_d_ready <= !r_src_i;
                        r_i_ready <= r_src_i;
                        if (r_src_i) r_i_line_out <= w_line_cap;
                        else         r_d_line_out <= w_line_cap;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt != LAST) r_mem_a <= w_next_a;
                    end
                end
                S_WRITE: begin
                    if (!w_io_stall) begin
                        if (r_cnt == LAST) begin
                            r_wr_en   <= 1'b0;
                            r_state   <= S_DONE;
                            r_d_ready <= !r_src_i;
                            r_i_ready <= r_src_i;
                        end else begin
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_mem_a    <= w_next_a;
                            r_mem_dout <= r_line[8*w_nxt_idx +: 8];
                        end
                    end
                end
                S_DONE: begin
                    // the just-served requester's valid may still be stale next cycle
                    r_d_mask <= !r_src_i;
                    r_i_mask <= r_src_i;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrler.sv
// Directed scoreboard bench for mem_ctrler: stimulus pushes expected writes/responses, a negedge monitor pops and compares.
module tb_mem_ctrler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrler_if #(.LINE_BYTES(16), .ADDR_W(32)) bus ();
    mem_ctrler dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

    // RAM model: byte value = address[7:0], returned one enabled cycle after the address
    always @(posedge clk) if (rdy) bus.mem_din <= bus.mem_a[7:0];

    typedef struct { logic rd; logic [127:0] line; int cyc; } resp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    resp_t d_q[$];
    resp_t i_q[$];
    wr_t   w_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ram_line(input logic [31:0] base);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'(base + 32'(k));
        return l;
    endfunction

    function automatic logic [127:0] pat_line(input logic [7:0] first);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = first + 8'(k);
        return l;
    endfunction

    task automatic push_wr(input logic [31:0] base, input logic [127:0] line, input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.a = base + 32'(k);
            w.d = line[8*k +: 8];
            w_q.push_back(w);
        end
    endtask

    // call at #1 after a posedge; holds valid until ready, drops it after the next edge
    task automatic req(input logic is_i, input logic rw, input logic [31:0] addr,
                       input logic [127:0] wline, input logic [127:0] eline, input int lat);
        resp_t r;
        int    n;
        r.rd   = !rw;
        r.line = eline;
        r.cyc  = cyc + lat;
        if (is_i) begin
            i_q.push_back(r);
            bus.i_addr  = addr;
            bus.i_valid = 1'b1;
        end else begin
            d_q.push_back(r);
            bus.d_rw_flag = rw;
            bus.d_addr    = addr;
            bus.d_line_in = wline;
            bus.d_valid   = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_i ? bus.i_ready : bus.d_ready) && n < 200);
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready in %0d cycles want ready", is_i ? "i" : "d", n);
        end
        @(posedge clk);
        #1;
        if (is_i) bus.i_valid = 1'b0;
        else      bus.d_valid = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        wr_t   w;
        resp_t r;
        if (bus.mem_wr === 1'b1) begin
            if (w_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got a=%h d=%h want no write", bus.mem_a, bus.mem_dout);
            end else begin
                w = w_q.pop_front();
                chk("wr_addr", 128'(bus.mem_a), 128'(w.a));
                chk("wr_data", 128'(bus.mem_dout), 128'(w.d));
            end
        end
        if (bus.d_ready === 1'b1) begin
            if (d_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d_ready_unexpected: got 1 want 0 at cycle %0d", cyc);
            end else begin
                r = d_q.pop_front();
                if (r.rd) chk("d_line", bus.d_line_out, r.line);
                chk("d_latency", 128'(cyc), 128'(r.cyc));
            end
        end
        if (bus.i_ready === 1'b1) begin
            if (i_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL i_ready_unexpected: got 1 want 0 at cycle %0d", cyc);
            end else begin
                r = i_q.pop_front();
                if (r.rd) chk("i_line", bus.i_line_out, r.line);
                chk("i_latency", 128'(cyc), 128'(r.cyc));
            end
        end
    end

    initial begin
        logic [127:0] l;
        bus.d_valid = 1'b0;
        bus.d_rw_flag = 1'b0;
        bus.d_addr = '0;
        bus.d_line_in = '0;
        bus.i_valid = 1'b0;
        bus.i_addr = '0;
        bus.io_buffer_full = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_ready", 128'(bus.d_ready), 128'(0));
        chk("rst_i_ready", 128'(bus.i_ready), 128'(0));
        chk("rst_mem_wr", 128'(bus.mem_wr), 128'(0));
        chk("rst_mem_a", 128'(bus.mem_a), 128'(0));
        chk("rst_mem_dout", 128'(bus.mem_dout), 128'(0));
        chk("rst_d_line", bus.d_line_out, 128'(0));
        chk("rst_i_line", bus.i_line_out, 128'(0));
        rst = 1'b0;
        gap();

        // d read, then d write
        req(1'b0, 1'b0, 32'h0000_1234, '0, 128'h3F3E3D3C3B3A39383736353433323130, 18);
        gap();
        l = pat_line(8'hA0);
        push_wr(32'h0000_2000, l, 16);
        req(1'b0, 1'b1, 32'h0000_2008, l, '0, 17);
        gap();

        // simultaneous d and i: d first, i accepted in the IDLE cycle after d's DONE
        fork
            req(1'b0, 1'b0, 32'h0000_1234, '0, ram_line(32'h0000_1230), 18);
            req(1'b1, 1'b0, 32'h0000_4050, '0, 128'h5F5E5D5C5B5A59585756555453525150, 37);
        join
        gap();

        // IO-region write with the sink full in cycles 3..5
        l = pat_line(8'h10);
        push_wr(32'h0003_0000, l, 16);
        fork
            req(1'b0, 1'b1, 32'h0003_0000, l, '0, 20);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.io_buffer_full = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("io_stall_no_wr", 128'(bus.mem_wr), 128'(0));
                    @(posedge clk);
                    #1;
                end
                bus.io_buffer_full = 1'b0;
            end
        join
        gap();

        // rdy low in cycles 6..9 of a read
        fork
            req(1'b0, 1'b0, 32'h0000_1234, '0, ram_line(32'h0000_1230), 22);
            begin
                repeat (6) @(posedge clk);
                #1;
                rdy = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_mem_a", 128'(bus.mem_a), 128'(32'h0000_1235));
                    chk("stall_mem_wr", 128'(bus.mem_wr), 128'(0));
                    @(posedge clk);
                    #1;
                end
                rdy = 1'b1;
            end
        join
        gap();

        // reset while byte 7 of a write is on the bus
        l = pat_line(8'h60);
        push_wr(32'h0000_5000, l, 8);
        bus.d_rw_flag = 1'b1;
        bus.d_addr = 32'h0000_5000;
        bus.d_line_in = l;
        bus.d_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.d_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_wr", 128'(bus.mem_wr), 128'(0));
        chk("post_rst_d_ready", 128'(bus.d_ready), 128'(0));
        chk("post_rst_mem_a", 128'(bus.mem_a), 128'(0));
        gap();
        push_wr(32'h0000_5000, l, 16);
        req(1'b0, 1'b1, 32'h0000_5000, l, '0, 17);
        gap();

        // top-of-space line and a lone instruction read
        req(1'b0, 1'b0, 32'hFFFF_FFFF, '0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 18);
        gap();
        req(1'b1, 1'b0, 32'h0000_00A7, '0, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 18);
        gap();

        chk("d_q_left", 128'(d_q.size()), 128'(0));
        chk("i_q_left", 128'(i_q.size()), 128'(0));
        chk("w_q_left", 128'(w_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrler.md
Name: mem_ctrler

Overview:
- Responder end of the cache-line memory protocol.
- Serves whole-line read and write requests from two requesters, the data-side load/store buffer (port d_) and the instruction cache (port i_, read-only).
- Serialises each request into byte accesses on the 8-bit external RAM/IO bus, then returns the assembled line or acknowledges the write.
- Sits between the cache-owning blocks and the top-level memory pins.

Parameters:
- LINE_BYTES, 16, bytes per cache line; line width = 8*LINE_BYTES bits.
- OFFSET_W, 4, log2(LINE_BYTES); low address bits ignored when aligning.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when 0 all state holds
- d_valid  in  1  data requester holds high until d_ready pulse
- d_rw_flag  in  1  0 = read line, 1 = write line
- d_addr  in  ADDR_W  any address inside the target line
- d_line_in  in  8*LINE_BYTES  write data, byte k at bits [8k+7:8k]
- d_ready  out  1  one-cycle completion pulse
- d_line_out  out  8*LINE_BYTES  read data, valid while d_ready=1
- i_valid  in  1  instruction requester, read only
- i_addr  in  ADDR_W  instruction line address
- i_ready  out  1  one-cycle completion pulse
- i_line_out  out  8*LINE_BYTES  read data, valid while i_ready=1
- mem_din  in  8  RAM read byte; valid one cycle after its address is driven
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO sink cannot accept a write

Behaviour:
- Reset (rst=1 at posedge): state IDLE, counter 0. d_ready=i_ready=0, mem_wr=0, mem_a=0, mem_dout=0, d_line_out=i_line_out=0. Any in-flight request is dropped with no ready pulse; the requester re-issues it.
- rdy=0: no register changes, including the counter. mem_wr is forced to 0 combinationally, so a stalled byte is never written twice.
- States: IDLE, READ, WRITE, DONE.
- IDLE, arbitration: d_valid has priority over i_valid.
  - The winner is latched: base = addr with the low OFFSET_W bits cleared, rw, source, and for writes the whole line.
  - Counter is set to 0; next state is READ or WRITE.
  - A requester whose ready pulsed in the previous cycle is not sampled in IDLE that cycle, because its valid may still be stale.
- READ:
  - Issue cycle c (c=0..LINE_BYTES-1) drives mem_a=base+c, mem_wr=0.
  - The byte returned on mem_din in cycle c+1 is stored at line byte c.
  - After capturing byte LINE_BYTES-1, go to DONE.
- WRITE:
  - Issue cycle c drives mem_a=base+c, mem_dout=line byte c, mem_wr=1.
  - If io_buffer_full=1 and base[17:16]==2'b11 (IO region), that cycle drives mem_wr=0 and the counter does not advance.
  - After byte LINE_BYTES-1 is written, go to DONE.
- DONE:
  - Pulse the source's ready for exactly one cycle; for reads, present the line on the matching *_line_out in the same cycle.
  - Return to IDLE.
  - The other port's ready stays 0.
- Latency (rdy=1, no IO stall), counted from the posedge that samples valid in IDLE:
  - Read: ready is high in cycle LINE_BYTES+2 (18 for the default).
  - Write: ready is high in cycle LINE_BYTES+1 (17).
- Address arithmetic: base+c is ADDR_W-bit modular, with no carry out of the line.
- Both valids high in IDLE: d is served first. i must stay asserted and is served right after d's DONE (starvation of i is acceptable).
- A valid that drops mid-transfer is ignored; the transfer completes and ready still pulses.
- mem_a is held at the last driven address in IDLE/DONE, with mem_wr=0.

Test Plan:
- d read at d_addr=0x1234 (base 0x1230), RAM holds byte value = address[7:0] -> mem_a steps 0x1230..0x123F; d_ready pulses once at cycle 18; d_line_out = 0x3F3E...3130.
- d write at 0x2008, d_line_in bytes 0xA0..0xAF -> mem_wr=1 on 16 consecutive cycles at 0x2000..0x200F with matching bytes; d_ready at cycle 17; i_ready stays 0.
- d_valid and i_valid rise together -> d is served fully first; i read starts the cycle after d's DONE; exactly one pulse each.
- IO write to 0x30000 with io_buffer_full high for cycles 3-5 -> no mem_wr on those cycles; byte count stays 16; ready is delayed by 3 cycles.
- rdy low for 4 cycles mid-read -> mem_a and counter frozen, mem_wr=0; resulting line identical to the unstalled run.
- rst asserted at byte 7 of a write -> next cycle IDLE, mem_wr=0, no ready; a fresh request then completes normally.
